// File: rtl/recirc_pkg.sv
// Shared defaults and helpers for the lane recirculation block.
package recirc_pkg;

  localparam int unsigned DefLanes = 4;
  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDepth = 4;
  localparam int unsigned DefCntW  = 16;

  typedef logic [DefLanes*DefWidth-1:0] lane_bus_t;

  // Bit offset of a lane inside the packed lane bus.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/recirc_fifo.sv
// Synchronous show-ahead FIFO; head reads as zero while empty.
module recirc_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

  // Extra pointer MSB separates the full case from the empty case.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop && !empty) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_L && push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/recirc_lanes.sv
// Lane demux: valid words go to a forward register, invalid words into the recirculation FIFO.
module recirc_lanes
  import recirc_pkg::*;
#(
  parameter int unsigned LANES = DefLanes,
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic                   valid_in,
  input  logic [LANES*WIDTH-1:0] data_in,
  output logic [LANES*WIDTH-1:0] data_mux,
  output logic                   valid_mux,
  output logic [LANES*WIDTH-1:0] probe_data,
  output logic                   probe_valid,
  input  logic                   probe_ready,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic [CNT_W-1:0]       recirc_count,
  output logic [CNT_W-1:0]       drop_count
);

  logic [LANES*WIDTH-1:0] data_mux_q, data_mux_d;
  logic                   valid_mux_q;
  logic [CNT_W-1:0]       recirc_q, drop_q;
  logic                   pop, push_req, push_ok;

  assign probe_valid = !fifo_empty;
  assign pop         = probe_valid && probe_ready;
  assign push_req    = !valid_in;
  // A pop in the same cycle frees the slot for a push into a full FIFO.
  assign push_ok     = push_req && (!fifo_full || pop);

  always_comb begin
    data_mux_d = '0;
    for (int k = 0; k < LANES; k++) begin
      if (valid_in) data_mux_d[lane_lsb(k, WIDTH) +: WIDTH] = data_in[lane_lsb(k, WIDTH) +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      data_mux_q  <= '0;
      valid_mux_q <= 1'b0;
      recirc_q    <= '0;
      drop_q      <= '0;
    end else begin
      data_mux_q  <= data_mux_d;
      valid_mux_q <= valid_in;
      if (push_ok && recirc_q != '1) recirc_q <= recirc_q + CNT_W'(1);
      if (push_req && !push_ok && drop_q != '1) drop_q <= drop_q + CNT_W'(1);
    end
  end

  recirc_fifo #(
    .WIDTH(LANES*WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_L(reset_L),
    .push   (push_ok),
    .pop    (pop),
    .wdata  (data_in),
    .rdata  (probe_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign data_mux     = data_mux_q;
  assign valid_mux    = valid_mux_q;
  assign recirc_count = recirc_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_recirc_lanes.sv
// Randomized bench for recirc_lanes against a queue-based model; a CNT_W=2 copy checks saturation.
module tb_recirc_lanes;
  import recirc_pkg::*;

  localparam int unsigned Depth = 4;
  localparam int unsigned BW    = DefLanes * DefWidth;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          valid_in;
  logic [BW-1:0] data_in;
  logic          probe_ready;

  logic [BW-1:0] data_mux, probe_data, data_mux_b, probe_data_b;
  logic          valid_mux, probe_valid, fifo_full, fifo_empty;
  logic          valid_mux_b, probe_valid_b, fifo_full_b, fifo_empty_b;
  logic [15:0]   recirc_count, drop_count;
  logic [1:0]    recirc_count_b, drop_count_b;

  int n_checks = 0;
  int n_fail   = 0;

  lane_bus_t q[$];
  lane_bus_t exp_fwd;
  logic      exp_fv;
  int        rc, dc, rc2, dc2;

  always #5 clk = ~clk;

  recirc_lanes #(.LANES(DefLanes), .WIDTH(DefWidth), .DEPTH(Depth), .CNT_W(16)) dut (
    .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
    .data_mux(data_mux), .valid_mux(valid_mux), .probe_data(probe_data),
    .probe_valid(probe_valid), .probe_ready(probe_ready), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .recirc_count(recirc_count), .drop_count(drop_count)
  );

  recirc_lanes #(.LANES(DefLanes), .WIDTH(DefWidth), .DEPTH(Depth), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
    .data_mux(data_mux_b), .valid_mux(valid_mux_b), .probe_data(probe_data_b),
    .probe_valid(probe_valid_b), .probe_ready(probe_ready), .fifo_full(fifo_full_b),
    .fifo_empty(fifo_empty_b), .recirc_count(recirc_count_b), .drop_count(drop_count_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v, input int max);
    return (v < max) ? v + 1 : v;
  endfunction

  task automatic compare_all();
    lane_bus_t head;
    head = (q.size() > 0) ? q[0] : '0;
    check("data_mux", 64'(data_mux), 64'(exp_fwd));
    check("valid_mux", 64'(valid_mux), 64'(exp_fv));
    check("probe_valid", 64'(probe_valid), 64'(q.size() > 0));
    check("probe_data", 64'(probe_data), 64'(head));
    check("fifo_full", 64'(fifo_full), 64'(q.size() == Depth));
    check("fifo_empty", 64'(fifo_empty), 64'(q.size() == 0));
    check("recirc_count", 64'(recirc_count), 64'(rc));
    check("drop_count", 64'(drop_count), 64'(dc));
    check("sat_probe_data", 64'(probe_data_b), 64'(head));
    check("sat_data_mux", 64'(data_mux_b), 64'(exp_fwd));
    check("sat_recirc_count", 64'(recirc_count_b), 64'(rc2));
    check("sat_drop_count", 64'(drop_count_b), 64'(dc2));
  endtask

  // Drive one cycle, advance the model at the edge, compare on the falling edge.
  task automatic step(input logic vin, input lane_bus_t din, input logic rdy, input logic rst_n);
    bit did_pop, room;
    valid_in    = vin;
    data_in     = din;
    probe_ready = rdy;
    reset_L     = rst_n;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      exp_fwd = '0; exp_fv = 1'b0;
      rc = 0; dc = 0; rc2 = 0; dc2 = 0;
    end else begin
      exp_fwd = vin ? din : '0;
      exp_fv  = vin;
      did_pop = rdy && (q.size() > 0);
      room    = (q.size() < Depth) || did_pop;
      if (did_pop) void'(q.pop_front());
      if (!vin) begin
        if (room) begin
          q.push_back(din);
          rc  = sat_inc(rc, 65535);
          rc2 = sat_inc(rc2, 3);
        end else begin
          dc  = sat_inc(dc, 65535);
          dc2 = sat_inc(dc2, 3);
        end
      end
    end
    @(negedge clk);
    compare_all();
  endtask

  function automatic lane_bus_t rand_word();
    return lane_bus_t'($urandom);
  endfunction

  initial begin
    reset_L = 1'b0; valid_in = 1'b1; data_in = '0; probe_ready = 1'b0;
    @(negedge clk);
    step(1'b1, '0, 1'b0, 1'b0);
    step(1'b1, '0, 1'b0, 1'b0);

    // Forward path.
    step(1'b1, 32'hDDCCBBAA, 1'b0, 1'b1);

    // Two recirculated words, then drain.
    step(1'b0, 32'h11111111, 1'b0, 1'b1);
    step(1'b0, 32'h22222222, 1'b0, 1'b1);
    step(1'b1, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h0, 1'b1, 1'b1);

    // Overflow: six pushes into a depth-4 FIFO, then drain in order.
    for (int i = 0; i < 6; i++) step(1'b0, rand_word(), 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, rand_word(), 1'b1, 1'b1);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 4; i++) step(1'b0, rand_word(), 1'b0, 1'b1);
    step(1'b0, rand_word(), 1'b1, 1'b1);
    step(1'b0, rand_word(), 1'b1, 1'b1);

    // Mid-operation reset with inputs active.
    step(1'b1, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, rand_word(), 1'b0, 1'b1);
    step(1'b0, rand_word(), 1'b1, 1'b0);
    step(1'b1, rand_word(), 1'b0, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 99) < 45), rand_word(), 1'($urandom_range(0, 99) < 40),
           1'($urandom_range(0, 99) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
